kp_note_ctrl: RTL and testbench

KP_NOTE_CTRL -- requirements
Module: kp_note_ctrl

---
 rtl/kp_pkg.sv | 55 +++++
 rtl/kp_midi_parser.sv | 79 +++++++
 rtl/kp_note_ctrl.sv | 134 +++++++++++++
 tb/tb_kp_note_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared constants, MIDI event type and note-to-delay tuning table for the
// Karplus-Strong note controller.
package kp_pkg;

  localparam logic [6:0]  NOTE_MIN    = 7'd21;
  localparam logic [6:0]  NOTE_MAX    = 7'd108;

  localparam logic [3:0]  ST_NOTE_OFF = 4'h8;
  localparam logic [3:0]  ST_NOTE_ON  = 4'h9;
  localparam logic [7:0]  RT_FIRST    = 8'hF8;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef struct packed {
    logic [6:0] note;
    logic [6:0] velocity;
    logic       is_on;
  } note_event_t;

  // round(96000 / (440 * 2^((n-69)/12))), out-of-range notes clamp to the piano range
  function automatic logic [14:0] note_delay(input logic [6:0] note);
    logic [6:0]  n;
    logic [14:0] d;
    if (note < NOTE_MIN)      n = NOTE_MIN;
    else if (note > NOTE_MAX) n = NOTE_MAX;
    else                      n = note;
    case (n)
      7'd21:  d = 15'd3491; 7'd22:  d = 15'd3295; 7'd23:  d = 15'd3110; 7'd24:  d = 15'd2935;
      7'd25:  d = 15'd2771; 7'd26:  d = 15'd2615; 7'd27:  d = 15'd2468; 7'd28:  d = 15'd2330;
      7'd29:  d = 15'd2199; 7'd30:  d = 15'd2076; 7'd31:  d = 15'd1959; 7'd32:  d = 15'd1849;
      7'd33:  d = 15'd1745; 7'd34:  d = 15'd1647; 7'd35:  d = 15'd1555; 7'd36:  d = 15'd1468;
      7'd37:  d = 15'd1385; 7'd38:  d = 15'd1308; 7'd39:  d = 15'd1234; 7'd40:  d = 15'd1165;
      7'd41:  d = 15'd1100; 7'd42:  d = 15'd1038; 7'd43:  d = 15'd980;  7'd44:  d = 15'd925;
      7'd45:  d = 15'd873;  7'd46:  d = 15'd824;  7'd47:  d = 15'd778;  7'd48:  d = 15'd734;
      7'd49:  d = 15'd693;  7'd50:  d = 15'd654;  7'd51:  d = 15'd617;  7'd52:  d = 15'd582;
      7'd53:  d = 15'd550;  7'd54:  d = 15'd519;  7'd55:  d = 15'd490;  7'd56:  d = 15'd462;
      7'd57:  d = 15'd436;  7'd58:  d = 15'd412;  7'd59:  d = 15'd389;  7'd60:  d = 15'd367;
      7'd61:  d = 15'd346;  7'd62:  d = 15'd327;  7'd63:  d = 15'd309;  7'd64:  d = 15'd291;
      7'd65:  d = 15'd275;  7'd66:  d = 15'd259;  7'd67:  d = 15'd245;  7'd68:  d = 15'd231;
      7'd69:  d = 15'd218;  7'd70:  d = 15'd206;  7'd71:  d = 15'd194;  7'd72:  d = 15'd183;
      7'd73:  d = 15'd173;  7'd74:  d = 15'd163;  7'd75:  d = 15'd154;  7'd76:  d = 15'd146;
      7'd77:  d = 15'd137;  7'd78:  d = 15'd130;  7'd79:  d = 15'd122;  7'd80:  d = 15'd116;
      7'd81:  d = 15'd109;  7'd82:  d = 15'd103;  7'd83:  d = 15'd97;   7'd84:  d = 15'd92;
      7'd85:  d = 15'd87;   7'd86:  d = 15'd82;   7'd87:  d = 15'd77;   7'd88:  d = 15'd73;
      7'd89:  d = 15'd69;   7'd90:  d = 15'd65;   7'd91:  d = 15'd61;   7'd92:  d = 15'd58;
      7'd93:  d = 15'd55;   7'd94:  d = 15'd51;   7'd95:  d = 15'd49;   7'd96:  d = 15'd46;
      7'd97:  d = 15'd43;   7'd98:  d = 15'd41;   7'd99:  d = 15'd39;   7'd100: d = 15'd36;
      7'd101: d = 15'd34;   7'd102: d = 15'd32;   7'd103: d = 15'd31;   7'd104: d = 15'd29;
      7'd105: d = 15'd27;   7'd106: d = 15'd26;   7'd107: d = 15'd24;   7'd108: d = 15'd23;
      default: d = 15'd23;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/kp_midi_parser.sv
// MIDI note-on/note-off parser with running status; emits a one-cycle event
// in the same cycle the final data byte is accepted.
module kp_midi_parser
  import kp_pkg::*;
(
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic [7:0]  midi_data,
  input  logic        byte_fire,
  input  logic [3:0]  channel,
  input  logic        omni,
  output logic        ev_valid,
  output note_event_t ev
);

  typedef enum logic [1:0] {WAIT_STATUS, DATA1, DATA2} parse_state_t;

  parse_state_t state;
  logic         rs_valid;
  logic         rs_is_on;
  logic [6:0]   note_q;

  logic is_status;
  logic is_realtime;
  logic is_note_status;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    is_status      = midi_data[7];
    is_realtime    = (midi_data >= RT_FIRST);
    is_note_status = ((midi_data[7:4] == ST_NOTE_OFF) || (midi_data[7:4] == ST_NOTE_ON))
                     && (omni || (midi_data[3:0] == channel));
  end

  // Combinational so the strike engine can register the note on the accepting edge
  assign ev_valid    = byte_fire && !midi_data[7] && (state == DATA2);
  assign ev.note     = note_q;
  assign ev.velocity = midi_data[6:0];
  assign ev.is_on    = rs_is_on && (midi_data[6:0] != 7'd0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      state    <= WAIT_STATUS;
      rs_valid <= 1'b0;
      rs_is_on <= 1'b0;
      note_q   <= '0;
    end else if (byte_fire) begin
      if (is_status) begin
        if (!is_realtime) begin
          if (is_note_status) begin
            rs_valid <= 1'b1;
            rs_is_on <= (midi_data[7:4] == ST_NOTE_ON);
            state    <= DATA1;
          end else begin
            rs_valid <= 1'b0;
            state    <= WAIT_STATUS;
          end
        end
      end else begin
        case (state)
          WAIT_STATUS: begin
            if (rs_valid) begin
              note_q <= midi_data[6:0];
              state  <= DATA2;
            end
          end
          DATA1: begin
            note_q <= midi_data[6:0];
            state  <= DATA2;
          end
          DATA2:   state <= WAIT_STATUS;
          default: state <= WAIT_STATUS;
        endcase
      end
    end
  end

endmodule

// File: rtl/kp_note_ctrl.sv
// Note controller: turns parsed MIDI notes into timed active-low strikes with
// delay-line tuning, plus a free-running excitation noise source.
module kp_note_ctrl
  import kp_pkg::*;
#(
  parameter int          TRIG_HOLD = 8,
  parameter int          TRIG_GAP  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
  input  logic               a_clk,
  input  logic               reset_n,
  input  logic [7:0]         midi_data,
  input  logic               midi_valid,
  output logic               midi_ready,
  input  logic [3:0]         channel,
  input  logic               omni,
  output logic               trig,
  output logic [6:0]         velocity,
  output logic [14:0]        delay_length,
  output logic signed [15:0] dnoise,
  output logic               note_active,
  output logic [6:0]         cur_note
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} eng_state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(TRIG_HOLD - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(TRIG_GAP - 1);

  eng_state_t  eng_state;
  logic [15:0] cnt;
  logic        pend_valid;
  note_event_t pend;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;

  logic        byte_fire;
  logic        ev_valid;
  note_event_t ev;
  logic        ev_on;
  logic        ev_off;
  logic        gap_done;
  logic        strike_now;
  note_event_t strike_ev;

  assign byte_fire  = midi_valid && midi_ready;
  assign midi_ready = !(pend_valid && (eng_state == HOLD));
  assign dnoise     = lfsr_q;

  kp_midi_parser u_parser (
    .a_clk     (a_clk),
    .reset_n   (reset_n),
    .midi_data (midi_data),
    .byte_fire (byte_fire),
    .channel   (channel),
    .omni      (omni),
    .ev_valid  (ev_valid),
    .ev        (ev)
  );

  // A fresh note-on beats the pending slot: it would have overwritten it anyway
  always_comb begin
    ev_on      = ev_valid && ev.is_on;
    ev_off     = ev_valid && !ev.is_on;
    gap_done   = (eng_state == GAP) && (cnt == '0);
    strike_now = 1'b0;
    strike_ev  = ev;
    if (ev_on && ((eng_state == IDLE) || gap_done)) begin
      strike_now = 1'b1;
    end else if (pend_valid && gap_done) begin
      strike_now = 1'b1;
      strike_ev  = pend;
    end
  end

  always_comb begin
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    if (lfsr_next == 16'h0000) lfsr_next = 16'h0001;
  end

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      eng_state    <= IDLE;
      cnt          <= '0;
      pend_valid   <= 1'b0;
      pend         <= '0;
      trig         <= 1'b1;
      velocity     <= '0;
      delay_length <= '0;
      note_active  <= 1'b0;
      cur_note     <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next;

      case (eng_state)
        HOLD: begin
          if (cnt == '0) begin
            eng_state <= GAP;
            trig      <= 1'b1;
            cnt       <= GAP_LOAD;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt == '0) eng_state <= IDLE;
          else           cnt       <= cnt - 16'd1;
        end
        default: ;
      endcase

      if (ev_on && !strike_now) begin
        pend_valid <= 1'b1;
        pend       <= ev;
      end

      if (ev_off && (ev.note == cur_note)) note_active <= 1'b0;

      // Strike last so it overrides the engine step and any same-cycle note-off
      if (strike_now) begin
        eng_state    <= HOLD;
        cnt          <= HOLD_LOAD;
        trig         <= 1'b0;
        velocity     <= strike_ev.velocity;
        cur_note     <= strike_ev.note;
        delay_length <= note_delay(strike_ev.note);
        note_active  <= 1'b1;
        pend_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kp_note_ctrl.sv
// Self-checking bench for kp_note_ctrl: directed MIDI sequences, a note table
// and randomized byte streams checked every cycle against a timeline model.
module tb_kp_note_ctrl;

  localparam int H = 8;
  localparam int G = 8;

  logic        a_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  midi_data = 8'h00;
  logic        midi_valid = 1'b0;
  logic        midi_ready;
  logic [3:0]  channel = 4'd0;
  logic        omni = 1'b0;
  logic        trig;
  logic [6:0]  velocity;
  logic [14:0] delay_length;
  logic [15:0] dnoise;
  logic        note_active;
  logic [6:0]  cur_note;

  kp_note_ctrl #(.TRIG_HOLD(H), .TRIG_GAP(G), .LFSR_SEED(16'hACE1)) dut (
    .a_clk        (a_clk),
    .reset_n      (reset_n),
    .midi_data    (midi_data),
    .midi_valid   (midi_valid),
    .midi_ready   (midi_ready),
    .channel      (channel),
    .omni         (omni),
    .trig         (trig),
    .velocity     (velocity),
    .delay_length (delay_length),
    .dnoise       (dnoise),
    .note_active  (note_active),
    .cur_note     (cur_note)
  );

  always #5 a_clk = ~a_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: parser rules on bytes, strike engine as a timeline of strike cycles
  int m_need, m_note, m_last, m_pnote, m_pvel, m_vel, m_cur, m_len, m_lfsr;
  bit m_rs, m_rs_on, m_pend, m_active;
  int cyc = 0;
  bit model_on = 1'b1;
  bit prev_trig = 1'b1;
  int fall_cyc[$];
  int fall_len[$];

  function automatic int ref_delay(input int n);
    int  c;
    real f;
    c = (n < 21) ? 21 : ((n > 108) ? 108 : n);
    f = 440.0 * $pow(2.0, (c - 69) / 12.0);
    return $rtoi(96000.0 / f + 0.5);
  endfunction

  function automatic bit m_in_hold();
    return (cyc >= m_last) && (cyc < m_last + H);
  endfunction

  function automatic bit m_ready();
    return !(m_pend && m_in_hold());
  endfunction

  task automatic model_edge(input bit v, input logic [7:0] d);
    int t, en, evel;
    bit ev, on;
    t = cyc + 1;
    ev = 1'b0; on = 1'b0; en = 0; evel = 0;
    if (!reset_n) begin
      m_need = 0; m_rs = 0; m_rs_on = 0; m_note = 0;
      m_last = -1000; m_pend = 0; m_pnote = 0; m_pvel = 0;
      m_vel = 0; m_cur = 0; m_len = 0; m_active = 0;
      m_lfsr = 'hACE1;
      cyc = t;
      return;
    end
    m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
    if (v && m_ready()) begin
      if (d >= 8'hF8) begin
      end else if (d[7]) begin
        if ((d[7:4] == 4'h8 || d[7:4] == 4'h9) && (omni || d[3:0] == channel)) begin
          m_rs = 1; m_rs_on = (d[7:4] == 4'h9); m_need = 2;
        end else begin
          m_rs = 0; m_need = 0;
        end
      end else if (m_need == 2 || (m_need == 0 && m_rs)) begin
        m_note = int'(d); m_need = 1;
      end else if (m_need == 1) begin
        ev = 1; on = m_rs_on && (d != 8'h00); en = m_note; evel = int'(d); m_need = 0;
      end
    end
    if (ev && !on && en == m_cur) m_active = 0;
    if (ev && on) begin m_pend = 1; m_pnote = en; m_pvel = evel; end
    if (m_pend && t >= m_last + H + G) begin
      m_last = t; m_cur = m_pnote; m_vel = m_pvel; m_len = ref_delay(m_pnote);
      m_active = 1; m_pend = 0;
    end
    cyc = t;
  endtask

  task automatic compare_model();
    logic [47:0] act, exp;
    act = {trig, velocity, delay_length, dnoise, note_active, cur_note, midi_ready};
    exp = {!m_in_hold(), 7'(m_vel), 15'(m_len), 16'(m_lfsr), m_active, 7'(m_cur), m_ready()};
    check($sformatf("model_cycle%0d", cyc), 64'(act), 64'(exp));
  endtask

  task automatic tick(input bit v, input logic [7:0] d);
    midi_valid = v;
    midi_data  = d;
    @(posedge a_clk);
    model_edge(v, d);
    @(negedge a_clk);
    if (model_on) compare_model();
    if (prev_trig === 1'b1 && trig === 1'b0) begin
      fall_cyc.push_back(cyc);
      fall_len.push_back(int'(delay_length));
    end
    prev_trig = trig;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic clear_falls();
    fall_cyc.delete();
    fall_len.delete();
  endtask

  typedef struct {
    int note;
    int vel;
    int exp_len;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, highs, guard, zeros, mism;

    vecs[0] = '{10,  64,  3491};
    vecs[1] = '{120, 33,  23};
    vecs[2] = '{69,  100, 218};
    vecs[3] = '{60,  80,  367};
    vecs[4] = '{21,  1,   3491};
    vecs[5] = '{108, 127, 23};
    vecs[6] = '{33,  5,   ref_delay(33)};
    vecs[7] = '{100, 90,  ref_delay(100)};

    // Reset state
    reset_n = 1'b0;
    idle(3);
    check("rst_trig", 64'(trig), 64'd1);
    check("rst_ready", 64'(midi_ready), 64'd1);
    check("rst_dnoise", 64'(dnoise), 64'hACE1);
    check("rst_velocity", 64'(velocity), 64'd0);
    check("rst_delay", 64'(delay_length), 64'd0);
    check("rst_note", 64'(cur_note), 64'd0);
    check("rst_active", 64'(note_active), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Single note-on: tuning, velocity and strike shape
    clear_falls();
    tick(1, 8'h90); tick(1, 8'h45); tick(1, 8'h64);
    check("t1_delay", 64'(delay_length), 64'd218);
    check("t1_velocity", 64'(velocity), 64'd100);
    check("t1_trig_n1", 64'(trig), 64'd0);
    check("t1_active", 64'(note_active), 64'd1);
    lows = 1; guard = 0;
    while (trig === 1'b0 && guard < 40) begin
      tick(0, 8'h00); guard++;
      if (trig === 1'b0) lows++;
    end
    check("t1_low_cycles", 64'(lows), 64'(H));
    highs = 0;
    repeat (G) begin
      if (trig === 1'b1) highs++;
      tick(0, 8'h00);
    end
    check("t1_gap_high", 64'(highs), 64'(G));
    idle(4);

    // Running status: second note pends behind the first strike
    clear_falls();
    tick(1, 8'h90); tick(1, 8'h3C); tick(1, 8'h50); tick(1, 8'h45); tick(1, 8'h40);
    idle(50);
    check("t2_strikes", 64'(fall_cyc.size()), 64'd2);
    if (fall_cyc.size() >= 2) begin
      check("t2_len_first", 64'(fall_len[0]), 64'd367);
      check("t2_len_second", 64'(fall_len[1]), 64'd218);
      check("t2_spacing_ge16", 64'((fall_cyc[1] - fall_cyc[0]) >= 16), 64'd1);
    end

    // Realtime byte inside a note-off; note-off never strikes
    tick(1, 8'h90); tick(1, 8'h3C); tick(1, 8'h50);
    idle(30);
    clear_falls();
    check("t3_active_before", 64'(note_active), 64'd1);
    tick(1, 8'h80); tick(1, 8'h3C); tick(1, 8'hF8); tick(1, 8'h00);
    check("t3_active_off", 64'(note_active), 64'd0);
    check("t3_note_kept", 64'(cur_note), 64'd60);
    idle(30);
    check("t3_no_pulse", 64'(fall_cyc.size()), 64'd0);

    // Channel filter and omni
    channel = 4'd3; omni = 1'b0;
    clear_falls();
    tick(1, 8'h92); tick(1, 8'h40); tick(1, 8'h7F);
    idle(30);
    check("t4_wrong_channel", 64'(fall_cyc.size()), 64'd0);
    omni = 1'b1;
    tick(1, 8'h92); tick(1, 8'h40); tick(1, 8'h7F);
    check("t4_omni_trig", 64'(trig), 64'd0);
    check("t4_omni_delay", 64'(delay_length), 64'd291);
    check("t4_omni_velocity", 64'(velocity), 64'd127);
    idle(30);
    omni = 1'b0; channel = 4'd0;

    // Note table including clamped notes
    foreach (vecs[i]) begin
      tick(1, 8'h90); tick(1, 8'(vecs[i].note)); tick(1, 8'(vecs[i].vel));
      check($sformatf("tbl_delay_n%0d", vecs[i].note), 64'(delay_length), 64'(vecs[i].exp_len));
      check($sformatf("tbl_vel_n%0d", vecs[i].note), 64'(velocity), 64'(vecs[i].vel));
      check($sformatf("tbl_note_n%0d", vecs[i].note), 64'(cur_note), 64'(vecs[i].note));
      idle(20);
    end

    // Reset in the third HOLD cycle with a note pending
    tick(1, 8'h90); tick(1, 8'h45); tick(1, 8'h64);
    tick(1, 8'h40); tick(1, 8'h70);
    check("t6_ready_low", 64'(midi_ready), 64'd0);
    check("t6_trig_hold3", 64'(trig), 64'd0);
    reset_n = 1'b0;
    tick(0, 8'h00);
    check("t6_trig_released", 64'(trig), 64'd1);
    check("t6_dnoise_seed", 64'(dnoise), 64'hACE1);
    check("t6_ready_high", 64'(midi_ready), 64'd1);
    reset_n = 1'b1;
    clear_falls();
    idle(40);
    check("t6_no_pending_fire", 64'(fall_cyc.size()), 64'd0);

    // Long noise run
    model_on = 1'b0;
    zeros = 0; mism = 0;
    repeat (70000) begin
      tick(0, 8'h00);
      if (dnoise === 16'h0000) zeros++;
      if (dnoise !== 16'(m_lfsr)) mism++;
    end
    check("lfsr_zero_cycles", 64'(zeros), 64'd0);
    check("lfsr_sequence_mismatches", 64'(mism), 64'd0);
    model_on = 1'b1;

    // Randomized byte stream against the model
    channel = 4'd5;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      logic [3:0] ch;
      r  = $urandom_range(0, 99);
      ch = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : channel;
      if (r < 15)      b = {4'h9, ch};
      else if (r < 25) b = {4'h8, ch};
      else if (r < 30) b = 8'($urandom_range(8'hA0, 8'hF7));
      else if (r < 35) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 42) b = 8'h00;
      else             b = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 199) == 0) omni = ~omni;
      reset_n = ($urandom_range(0, 799) != 0);
      tick($urandom_range(0, 3) != 0, b);
    end
    reset_n = 1'b1;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
